// File: rtl/fpdiv_arbiter.sv
// Two-requester round-robin front end for the shared single-precision divider:
// grants one operand pair, waits DIV_LAT cycles, and returns the tagged quotient.
module fpdiv_arbiter #(
  parameter int unsigned DIV_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic        div_overflow,
  input  logic        div_underflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        rsp_divzero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp_underflow_q, rsp_underflow_d;
  logic        rsp_divzero_q, rsp_divzero_d;
  logic        busy_q, busy_d;

  logic        gnt0, gnt1;
  logic        hs0, hs1;
  logic        divzero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      last_grant_q    <= 1'b1;
      div_a_q         <= '0;
      div_b_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_result_q    <= '0;
      rsp_overflow_q  <= 1'b0;
      rsp_underflow_q <= 1'b0;
      rsp_divzero_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_grant_q    <= last_grant_d;
      div_a_q         <= div_a_d;
      div_b_q         <= div_b_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_result_q    <= rsp_result_d;
      rsp_overflow_q  <= rsp_overflow_d;
      rsp_underflow_q <= rsp_underflow_d;
      rsp_divzero_q   <= rsp_divzero_d;
      busy_q          <= busy_d;
    end
  end

  // Requester 0 wins a tie only when requester 1 was served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign hs0 = gnt0 & req0_valid;
  assign hs1 = gnt1 & req1_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs0 || hs1) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign divzero = (div_b_q[30:0] == '0);

  always_comb begin
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    div_a_d         = div_a_q;
    div_b_d         = div_b_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_result_d    = rsp_result_q;
    rsp_overflow_d  = rsp_overflow_q;
    rsp_underflow_d = rsp_underflow_q;
    rsp_divzero_d   = rsp_divzero_q;
    case (state_q)
      IDLE: begin
        if (hs0 || hs1) begin
          div_a_d      = hs1 ? req1_a : req0_a;
          div_b_d      = hs1 ? req1_b : req0_b;
          rsp_id_d     = hs1;
          last_grant_d = hs1;
          cnt_d        = 4'(DIV_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          // Zero divisor bypasses the divider but keeps the same latency.
          if (divzero) begin
            rsp_result_d    = {div_a_q[31] ^ div_b_q[31], 8'hFF, 23'h0};
            rsp_overflow_d  = 1'b0;
            rsp_underflow_d = 1'b0;
            rsp_divzero_d   = 1'b1;
          end else begin
            rsp_result_d    = div_result;
            rsp_overflow_d  = div_overflow;
            rsp_underflow_d = div_underflow;
            rsp_divzero_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    req0_ready    = gnt0;
    req1_ready    = gnt1;
    div_a         = div_a_q;
    div_b         = div_b_q;
    rsp_valid     = rsp_valid_q;
    rsp_id        = rsp_id_q;
    rsp_result    = rsp_result_q;
    rsp_overflow  = rsp_overflow_q;
    rsp_underflow = rsp_underflow_q;
    rsp_divzero   = rsp_divzero_q;
    busy          = busy_q;
  end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Bench for fpdiv_arbiter: a registered divider stub plus a transaction-level
// model of grant order, latency and response contents.
module tb_fpdiv_arbiter;

  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic        dz;
    logic        ovf;
    logic        unf;
    logic [31:0] q;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] div_a, div_b;
  logic [31:0] div_result = '0;
  logic        div_overflow = 1'b0, div_underflow = 1'b0;
  logic        rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_divzero, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;
  bit model_last = 1'b1;
  logic [31:0] model_da = '0, model_db = '0;

  fpdiv_arbiter #(.DIV_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .div_overflow(div_overflow), .div_underflow(div_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .rsp_divzero(rsp_divzero),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] stub_q(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[7:0], b[31:8]} ^ 32'h5A5A0000;
  endfunction

  function automatic logic stub_ovf(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h7F000000 && b == 32'h00800000) || (a[3:0] == 4'hF && b[0]);
  endfunction

  function automatic logic stub_unf(input logic [31:0] a, input logic [31:0] b);
    return a[4] & b[5];
  endfunction

  // Divider stub: one register stage, so results are valid DIV_LAT cycles after operands.
  always @(posedge CLK) begin
    div_result    <= stub_q(div_a, div_b);
    div_overflow  <= stub_ovf(div_a, div_b);
    div_underflow <= stub_unf(div_a, div_b);
  end

  function automatic rsp_t expect_rsp(input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    if (b[30:0] == 31'h0) begin
      r.dz = 1'b1; r.ovf = 1'b0; r.unf = 1'b0;
      r.q  = {a[31] ^ b[31], 8'hFF, 23'h0};
    end else begin
      r.dz = 1'b0; r.ovf = stub_ovf(a, b); r.unf = stub_unf(a, b);
      r.q  = stub_q(a, b);
    end
    return r;
  endfunction

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if ({div_a, div_b, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow,
         rsp_divzero, busy, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL reset_values: got div_a=%h div_b=%h rsp_valid=%b rsp_result=%h busy=%b expected all 0",
               div_a, div_b, rsp_valid, rsp_result, busy);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_last = 1'b1; model_da = '0; model_db = '0;
    @(negedge CLK);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_grant: got ready=%b%b expected 10", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input rsp_t exp, input string name);
    int n;
    @(negedge CLK);
    rsp_ready = 1;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== (id ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL %s_grant: got ready=%b%b expected id %0d", name, req0_ready, req1_ready, id);
    end
    model_last = id; model_da = a; model_db = b;
    @(negedge CLK);
    req0_valid = 0; req1_valid = 0;
    #1;
    checks++;
    if ({div_a, div_b, busy, rsp_valid} !== {a, b, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL %s_operands: got div_a=%h div_b=%h busy=%b rsp_valid=%b expected %h %h 1 0",
               name, div_a, div_b, busy, rsp_valid, a, b);
    end
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin
      @(negedge CLK); #1; n++;
    end
    checks++;
    if (n != LAT + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, LAT + 1);
    end
    checks++;
    if ({rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result} !== {id, exp}) begin
      failures++;
      $display("FAIL %s_response: got id=%b dz=%b ovf=%b unf=%b q=%h expected id=%b dz=%b ovf=%b unf=%b q=%h",
               name, rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result,
               id, exp.dz, exp.ovf, exp.unf, exp.q);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL %s_release: got rsp_valid=%b busy=%b expected 0 0", name, rsp_valid, busy);
    end
  endtask

  task automatic test_single_op();
    do_op(1'b0, 32'h40C00000, 32'h40000000, '{dz: 1'b0, ovf: 1'b0, unf: 1'b0, q: 32'h40400000},
          "single_op");
  endtask

  task automatic test_divzero();
    do_op(1'b0, 32'h3F800000, 32'h80000000, '{dz: 1'b1, ovf: 1'b0, unf: 1'b0, q: 32'hFF800000},
          "divzero");
    do_op(1'b1, 32'hC0000000, 32'h00000000, '{dz: 1'b1, ovf: 1'b0, unf: 1'b0, q: 32'hFF800000},
          "divzero_neg");
  endtask

  task automatic test_flag_passthrough();
    do_op(1'b1, 32'h7F000000, 32'h00800000, expect_rsp(32'h7F000000, 32'h00800000), "overflow");
  endtask

  task automatic test_backpressure();
    rsp_t e0, e1;
    int n;
    e0 = expect_rsp(32'h41200000, 32'h40A00000);
    e1 = expect_rsp(32'hC1000000, 32'h3E800000);
    @(negedge CLK);
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h41200000; req0_b = 32'h40A00000;
    #1;
    model_last = 1'b0;
    @(negedge CLK);
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'hC1000000; req1_b = 32'h3E800000;
    #1;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin
      @(negedge CLK); #1; n++;
    end
    checks++;
    if (n != LAT + 1) begin
      failures++;
      $display("FAIL bp_latency: got %0d cycles expected %0d", n, LAT + 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result,
           req0_ready, req1_ready} !== {1'b1, 1'b0, e0, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got valid=%b id=%b q=%h ready=%b%b expected 1 0 %h 00",
                 i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready, e0.q);
      end
    end
    @(negedge CLK);
    rsp_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_nogrant: got req1_ready=%b expected 0", req1_ready);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      failures++;
      $display("FAIL bp_next_grant: got rsp_valid=%b ready=%b%b expected 0 01",
               rsp_valid, req0_ready, req1_ready);
    end
    model_last = 1'b1; model_da = 32'hC1000000; model_db = 32'h3E800000;
    @(negedge CLK);
    req1_valid = 0;
    #1;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin
      @(negedge CLK); #1; n++;
    end
    checks++;
    if (n != LAT + 1 || {rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result} !== {1'b1, e1}) begin
      failures++;
      $display("FAIL bp_second_rsp: got n=%0d id=%b q=%h expected n=%0d id=1 q=%h",
               n, rsp_id, rsp_result, LAT + 1, e1.q);
    end
    @(negedge CLK);
  endtask

  // Transaction-level model: single outstanding op, round-robin on ties,
  // response exactly LAT+1 cycles after the grant, idle the cycle after acceptance.
  task automatic run_random(input int n, input int unsigned pv, input int unsigned pr,
                            input string name);
    bit idle = 1'b1, pend = 1'b0;
    int due = 0;
    bit exp_id = 1'b0;
    rsp_t exp;
    bit v0, v1, e0, e1, exp_rv;
    logic [31:0] t;
    int k;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge CLK);
      v0 = ($urandom_range(99) < pv);
      v1 = ($urandom_range(99) < pv);
      req0_valid = v0; req1_valid = v1;
      req0_a = $urandom;
      t = $urandom; if ($urandom_range(7) == 0) t[30:0] = '0; req0_b = t;
      req1_a = $urandom;
      t = $urandom; if ($urandom_range(7) == 0) t[30:0] = '0; req1_b = t;
      rsp_ready = ($urandom_range(99) < pr);
      #1;
      e0 = idle && v0 && (!v1 || model_last);
      e1 = idle && v1 && !e0;
      exp_rv = pend && (cyc >= due);
      checks++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== {e0, e1, !idle, exp_rv}) begin
        failures++;
        $display("FAIL %s_ctrl: cycle %0d got ready=%b%b busy=%b rsp_valid=%b expected %b%b %b %b",
                 name, cyc, req0_ready, req1_ready, busy, rsp_valid, e0, e1, !idle, exp_rv);
      end
      checks++;
      if ({div_a, div_b} !== {model_da, model_db}) begin
        failures++;
        $display("FAIL %s_div_hold: cycle %0d got %h/%h expected %h/%h",
                 name, cyc, div_a, div_b, model_da, model_db);
      end
      if (exp_rv) begin
        checks++;
        if ({rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result} !== {exp_id, exp}) begin
          failures++;
          $display("FAIL %s_rsp: cycle %0d got id=%b dz=%b ovf=%b unf=%b q=%h expected id=%b dz=%b ovf=%b unf=%b q=%h",
                   name, cyc, rsp_id, rsp_divzero, rsp_overflow, rsp_underflow, rsp_result,
                   exp_id, exp.dz, exp.ovf, exp.unf, exp.q);
        end
        if (rsp_ready) begin
          pend = 1'b0;
          idle = 1'b1;
        end
      end
      if (e0 || e1) begin
        exp_id = e1;
        model_last = e1;
        model_da = e1 ? req1_a : req0_a;
        model_db = e1 ? req1_b : req0_b;
        exp = expect_rsp(model_da, model_db);
        pend = 1'b1;
        due = cyc + 1 + LAT;
        idle = 1'b0;
      end
    end
    @(negedge CLK);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    k = 0;
    #1;
    while ((busy !== 1'b0 || rsp_valid !== 1'b0) && k < 20) begin
      @(negedge CLK); #1; k++;
    end
    checks++;
    if (k >= 20) begin
      failures++;
      $display("FAIL %s_drain: got busy=%b rsp_valid=%b expected idle within 20 cycles",
               name, busy, rsp_valid);
    end
  endtask

  task automatic test_contention();
    run_random(60, 100, 60, "contention");
  endtask

  task automatic test_random();
    run_random(400, 45, 70, "random");
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    @(negedge CLK);
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'h40C00000; req0_b = 32'h40000000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstwait_grant: got req0_ready=%b expected 1", req0_ready);
    end
    @(negedge CLK);
    req0_valid = 0;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({div_a, div_b, rsp_valid, rsp_result, busy} !== '0) begin
      failures++;
      $display("FAIL rstwait_async: got div_a=%h div_b=%h rsp_valid=%b busy=%b expected all 0",
               div_a, div_b, rsp_valid, busy);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_last = 1'b1; model_da = '0; model_db = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstwait_no_rsp: got activity after reset expected rsp_valid=0 busy=0");
    end
    @(negedge CLK);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rstwait_first_grant: got ready=%b%b expected 10", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_divzero();
    test_flag_passthrough();
    test_backpressure();
    test_contention();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpdiv_arbiter.md
Name: fpdiv_arbiter

Overview:
Sequencer and two-port round-robin arbiter in front of the shared single-precision IEEE-754 divider datapath. It accepts operand pairs from two requesters over valid/ready handshakes and registers the winning pair onto the divider inputs. It waits a fixed datapath latency, then captures the quotient and the overflow/underflow flags. It returns them on one response channel tagged with the requester id. It also short-circuits divide-by-zero to a signed infinity with a dedicated flag.

Parameters:
DIV_LAT, 2, cycles from operands stable on div_a/div_b to div_result being sampled; legal range 1..15.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; asynchronous, active-high
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 granted this cycle
req0_a  in  32  requester 0 dividend
req0_b  in  32  requester 0 divisor
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 granted this cycle
req1_a  in  32  requester 1 dividend
req1_b  in  32  requester 1 divisor
div_a  out  32  registered dividend to the divider
div_b  out  32  registered divisor to the divider
div_result  in  32  divider quotient
div_overflow  in  1  divider overflow flag
div_underflow  in  1  divider underflow flag
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accepts
rsp_id  out  1  requester that owns the response
rsp_result  out  32  quotient
rsp_overflow  out  1  overflow flag
rsp_underflow  out  1  underflow flag
rsp_divzero  out  1  divisor was ±0
busy  out  1  state != IDLE

Behaviour:
- FSM has three states: IDLE, WAIT and RESP. Reset state is IDLE.
- On RST, all registered outputs go to 0: div_a, div_b, rsp_* and busy. The internal counter is cleared. last_grant is set to 1, so requester 0 wins first.
- Reset mid-operation drops the in-flight transaction. No response is produced for it.
- reqN_ready is combinational. It is high only in IDLE, only for the granted requester, and never for both at once.
- Grant in IDLE:
  - If only one requester is valid, that requester is granted.
  - If both are valid, grant goes to !last_grant.
- Handshake occurs on the edge where reqN_valid and reqN_ready are both high. On that edge:
  - reqN_a/reqN_b are latched into div_a/div_b.
  - rsp_id and last_grant are set to N.
  - cnt is loaded with DIV_LAT-1.
  - State moves to WAIT.
- A requester may drop valid before it is granted. Operands are sampled only at the handshake edge.
- div_a/div_b hold their value outside handshake edges, including IDLE. This avoids needless toggling of the divider.
- In WAIT, cnt decrements each cycle. On the edge where cnt==0:
  - rsp_result and the flags are captured.
  - rsp_valid is set to 1.
  - State moves to RESP.
- Latency: a handshake in cycle t gives rsp_valid first high in cycle t+1+DIV_LAT (t+3 at the default).
- Divide-by-zero:
  - The condition is divisor[30:0]==0, evaluated on the latched div_b.
  - rsp_result = {div_a[31]^div_b[31], 8'hFF, 23'h0}.
  - rsp_divzero=1, rsp_overflow=0, rsp_underflow=0.
  - Latency is unchanged, so timing stays deterministic.
- Normal case: rsp_result=div_result, rsp_overflow=div_overflow, rsp_underflow=div_underflow, rsp_divzero=0.
- In RESP, all rsp_* outputs hold stable while rsp_ready is low. On the edge with rsp_ready=1, rsp_valid clears and state moves to IDLE.
- There is no grant in the same cycle as the response handshake. The earliest next grant is the cycle after.
- Throughput: one operation per DIV_LAT+2 cycles minimum.
- A pending requester is served after at most one foreign transaction, so there is no starvation.
- busy is registered: 1 in WAIT and RESP, 0 in IDLE.

Test Plan:
- Single op: req0 A=0x40C00000, B=0x40000000, DIV_LAT=2, rsp_ready=1 → div_a/div_b updated the cycle after the handshake. rsp_valid rises exactly 3 cycles after the handshake with rsp_id=0, rsp_result=0x40400000 and all flags 0.
- Contention: both valid continuously with distinct operands → grants alternate 0,1,0,1. The ready signals are never both high. Each rsp_id matches its operands.
- Divide-by-zero: A=0x3F800000, B=0x80000000 → rsp_result=0xFF800000, rsp_divzero=1, overflow=underflow=0, at the same latency as a normal op.
- Backpressure: rsp_ready held low 10 cycles → rsp_* stable throughout, no reqN_ready asserted. On release, rsp_valid falls, and a pending request is granted one cycle later.
- Flag passthrough: divider stub drives div_overflow=1 on A=0x7F000000, B=0x00800000 → rsp_overflow=1, rsp_divzero=0.
- Reset mid-WAIT: RST asserted asynchronously 1 cycle after the handshake → outputs 0 immediately, no response produced, and req0 wins the first grant after release when both are valid.
